// File: rtl/mealy_fsm.sv
// Mealy serial sequence detector: Y flags the bit that completes PATTERN, with overlap.
// The transition table is derived from PATTERN at elaboration time (KMP prefix/suffix matching).
module mealy_fsm #(
  parameter int unsigned                PAT_LEN = 2,
  parameter logic        [PAT_LEN-1:0]  PATTERN = 2'b01
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  output logic Y
);

  localparam int unsigned SW     = (PAT_LEN < 2) ? 1 : $clog2(PAT_LEN);
  localparam int unsigned NSTATE = 2 ** SW;
  localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

  // Longest proper prefix of PATTERN that is a suffix of (k matched bits, then a).
  function automatic int unsigned next_k(input int unsigned k, input logic a);
    int unsigned best;
    int unsigned j;
    logic        ok;
    logic        c;
    best = 0;
    if (k >= PAT_LEN) return 0;
    for (int unsigned l = 1; l <= k + 1; l++) begin
      if (l < PAT_LEN) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < l; i++) begin
          j = k + 1 - l + i;
          c = (j < k) ? PATTERN[PAT_LEN-1-j] : a;
          if (c != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;
  logic [SW-1:0] tbl0 [NSTATE];
  logic [SW-1:0] tbl1 [NSTATE];

  // Table is padded to the full encoding space; unreachable codes map back to 0.
  for (genvar k = 0; k < NSTATE; k++) begin : g_tbl
    localparam int unsigned N0 = next_k(k, 1'b0);
    localparam int unsigned N1 = next_k(k, 1'b1);
    assign tbl0[k] = SW'(N0);
    assign tbl1[k] = SW'(N1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= '0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = A ? tbl1[state] : tbl0[state];
  end

  always_comb begin
    Y = 1'b0;
    if (reset && (state == LAST) && (A == PATTERN[0])) Y = 1'b1;
  end

endmodule

// File: tb/tb_mealy_fsm.sv
// Directed bench for mealy_fsm: default "01" detector plus a PAT_LEN=3 "101" instance.
module tb_mealy_fsm;

  logic clk;
  logic reset;
  logic A;
  logic A3;
  logic Y;
  logic Y3;

  int n_tests;
  int n_fail;

  mealy_fsm dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .Y     (Y)
  );

  mealy_fsm #(
    .PAT_LEN (3),
    .PATTERN (3'b101)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .A     (A3),
    .Y     (Y3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive both serial inputs mid-cycle, check the Mealy outputs before the sampling edge.
  task automatic step(input string tag, input logic a, input logic a3,
                      input logic ey, input logic ey3);
    @(negedge clk);
    A  = a;
    A3 = a3;
    #1;
    check({tag, " Y"}, int'(Y), int'(ey));
    check({tag, " Y3"}, int'(Y3), int'(ey3));
    @(posedge clk);
    #1;
  endtask

  logic long_a [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic long_y [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic p3_a  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic p3_y  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    A       = 1'b0;
    A3      = 1'b0;

    // Reset held: outputs and state stay zero whatever A does
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      A  = (i % 2 == 0);
      A3 = (i % 2 == 0);
      #1;
      check("rst Y", int'(Y), 0);
      check("rst Y3", int'(Y3), 0);
      check("rst state", int'(dut.state), 0);
    end

    // Release with A=1: nothing seen yet
    @(negedge clk);
    reset = 1'b1;
    A     = 1'b1;
    A3    = 1'b0;
    #1;
    check("release Y", int'(Y), 0);
    @(posedge clk);
    #1;
    check("release state", int'(dut.state), 0);

    // Basic detect
    step("basic0", 1'b0, 1'b0, 1'b0, 1'b0);
    step("basic1", 1'b1, 1'b0, 1'b1, 1'b0);
    step("basic2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Long-run stream
    for (int i = 0; i < 8; i++)
      step($sformatf("long%0d", i), long_a[i], 1'b0, long_y[i], 1'b0);

    // Repeated zeros hold S1
    for (int i = 0; i < 4; i++) begin
      step($sformatf("zeros%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("zeros%0d state", i), int'(dut.state), 1);
    end
    step("zeros_end", 1'b1, 1'b0, 1'b1, 1'b0);

    // Async reset mid-pattern: clears state without a clock edge
    step("ar0", 1'b0, 1'b1, 1'b0, 1'b0);
    check("ar pre state", int'(dut.state), 1);
    check("ar pre state3", int'(dut3.state), 1);
    #1;
    reset = 1'b0;
    #1;
    check("ar state", int'(dut.state), 0);
    check("ar state3", int'(dut3.state), 0);
    A = 1'b1;
    #1;
    check("ar Y forced", int'(Y), 0);
    reset = 1'b1;
    step("ar1", 1'b1, 1'b0, 1'b0, 1'b0);

    // "101" instance: overlap through border "1", mismatch from full prefix
    for (int i = 0; i < 10; i++)
      step($sformatf("p3_%0d", i), 1'b0, p3_a[i], 1'b0, p3_y[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
